// File: rtl/apb_pkg.sv
// Shared types for the APB master bridge: FSM state encoding, slave count and the latched command.
// Bus widths of the command record are fixed here and used as the bridge's default widths.
package apb_pkg;

    localparam int unsigned APB_NSLV   = 4;
    localparam int unsigned APB_ADDR_W = 32;
    localparam int unsigned APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_e;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_cmd_t;

endpackage

// File: rtl/apb_sel_decode.sv
// One-hot APB slave select from the two top address bits; all selects low when inactive.
module apb_sel_decode
    import apb_pkg::*;
(
    input  logic [1:0]          addr_top_i,
    input  logic                active_i,
    output logic [APB_NSLV-1:0] sel_o
);

    always_comb begin
        sel_o = '0;
        if (active_i) begin
            sel_o[addr_top_i] = 1'b1;
        end
    end

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB3 requester bridging a valid/ready command port to four APB slaves.
// Optional ACCESS-phase watchdog is enabled by defining APB_TIMEOUT_EN.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W      = APB_ADDR_W,
    parameter int unsigned DATA_W      = APB_DATA_W,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              sel1,
    output logic              sel2,
    output logic              sel3,
    output logic              sel4,
    output logic              write,
    output logic              enable,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    apb_state_e state_q, state_d;
    apb_cmd_t   cmd_q, cmd_d;

    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [APB_NSLV-1:0] sel_vec;
    logic              to_expire;

`ifdef APB_TIMEOUT_EN
    localparam int unsigned ToW = $clog2(TIMEOUT_CYC + 1);

    logic [ToW-1:0] to_cnt_q, to_cnt_d;

    // Counts ACCESS cycles; restarts on every SETUP so each transfer gets a full budget.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (state_q == SETUP) begin
            to_cnt_d = '0;
        end else if (state_q == ACCESS) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end

    assign to_expire = (to_cnt_q == ToW'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYC;
    assign to_expire      = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        req_ready   = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    cmd_d   = '{write: req_write, addr: req_addr, wdata: req_wdata};
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = PSLVERR;
                    rsp_rdata_d = cmd_q.write ? '0 : PRDATA;
                    req_ready   = 1'b1;
                    if (req_valid) begin
                        cmd_d   = '{write: req_write, addr: req_addr, wdata: req_wdata};
                        state_d = SETUP;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (to_expire) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Reset dominates: no command may be accepted in a reset cycle.
        if (PRESET) begin
            req_ready = 1'b0;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    apb_sel_decode u_sel_decode (
        .addr_top_i (cmd_q.addr[ADDR_W-1 -: 2]),
        .active_i   (state_q != IDLE),
        .sel_o      (sel_vec)
    );

    assign sel1      = sel_vec[0];
    assign sel2      = sel_vec[1];
    assign sel3      = sel_vec[2];
    assign sel4      = sel_vec[3];
    assign enable    = (state_q == ACCESS);
    // Direction/address/data hold their last value through IDLE.
    assign write     = cmd_q.write;
    assign addr      = cmd_q.addr;
    assign data      = cmd_q.wdata;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed self-checking bench for apb_master_bridge; timeout checks follow APB_TIMEOUT_EN.
module tb_apb_master_bridge;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        sel1, sel2, sel3, sel4;
    logic        write;
    logic        enable;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int checks = 0;
    int errors = 0;

    always #5 PCLK = ~PCLK;

    apb_master_bridge #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (16)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .sel1      (sel1),
        .sel2      (sel2),
        .sel3      (sel3),
        .sel4      (sel4),
        .write     (write),
        .enable    (enable),
        .addr      (addr),
        .data      (data),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Selects packed as {sel4,sel3,sel2,sel1}
    function automatic logic [31:0] sels();
        return {28'd0, sel4, sel3, sel2, sel1};
    endfunction

    task automatic request(input logic wr, input logic [31:0] a, input logic [31:0] wd);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = wd;
    endtask

    initial begin
        PRESET    = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h4000_0000;
        req_wdata = 32'hFFFF_FFFF;
        PRDATA    = 32'hFFFF_FFFF;
        PREADY    = 1'b1;
        PSLVERR   = 1'b1;

        // Reset held two cycles with a pending command
        tick();
        check("rst1_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        tick();
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_sels", sels(), 32'd0);
        check("rst_enable", {31'd0, enable}, 32'd0);
        check("rst_write", {31'd0, write}, 32'd0);
        check("rst_addr", addr, 32'd0);
        check("rst_data", data, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_err", {31'd0, rsp_err}, 32'd0);

        PRESET    = 1'b0;
        req_valid = 1'b0;
        PSLVERR   = 1'b0;
        #1;
        check("idle_req_ready", {31'd0, req_ready}, 32'd1);

        // Zero-wait write to slave 2
        request(1'b1, 32'h4000_0010, 32'hDEAD_BEEF);
        tick();
        req_valid = 1'b0;
        check("wr_setup_sels", sels(), 32'h2);
        check("wr_setup_enable", {31'd0, enable}, 32'd0);
        check("wr_setup_write", {31'd0, write}, 32'd1);
        check("wr_setup_addr", addr, 32'h4000_0010);
        check("wr_setup_data", data, 32'hDEAD_BEEF);
        check("wr_setup_ready", {31'd0, req_ready}, 32'd0);
        tick();
        check("wr_access_sels", sels(), 32'h2);
        check("wr_access_enable", {31'd0, enable}, 32'd1);
        check("wr_access_rsp", {31'd0, rsp_valid}, 32'd0);
        check("wr_access_ready", {31'd0, req_ready}, 32'd1);
        tick();
        check("wr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("wr_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("wr_rsp_rdata", rsp_rdata, 32'd0);
        check("wr_idle_sels", sels(), 32'd0);
        check("wr_idle_enable", {31'd0, enable}, 32'd0);
        check("wr_idle_addr_hold", addr, 32'h4000_0010);
        check("wr_idle_data_hold", data, 32'hDEAD_BEEF);
        tick();
        check("wr_rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);

        // Read to slave 4 with three wait states; PSLVERR while not ready must be ignored
        PREADY  = 1'b0;
        PSLVERR = 1'b1;
        request(1'b0, 32'hC000_0004, 32'h0);
        tick();
        req_valid = 1'b0;
        check("rd_setup_sels", sels(), 32'h8);
        check("rd_setup_write", {31'd0, write}, 32'd0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("rd_wait%0d_enable", i), {31'd0, enable}, 32'd1);
            check($sformatf("rd_wait%0d_sels", i), sels(), 32'h8);
            check($sformatf("rd_wait%0d_rsp", i), {31'd0, rsp_valid}, 32'd0);
            check($sformatf("rd_wait%0d_ready", i), {31'd0, req_ready}, 32'd0);
        end
        tick();
        PREADY  = 1'b1;
        PSLVERR = 1'b0;
        PRDATA  = 32'h1234_5678;
        #1;
        check("rd_acc4_enable", {31'd0, enable}, 32'd1);
        check("rd_acc4_ready", {31'd0, req_ready}, 32'd1);
        tick();
        PRDATA = 32'hFFFF_FFFF;
        check("rd_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("rd_rsp_rdata", rsp_rdata, 32'h1234_5678);
        check("rd_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("rd_idle_enable", {31'd0, enable}, 32'd0);

        // Read to slave 3 completing with PSLVERR
        request(1'b0, 32'h8000_0020, 32'h0);
        tick();
        req_valid = 1'b0;
        check("err_setup_sels", sels(), 32'h4);
        PSLVERR = 1'b1;
        PRDATA  = 32'hA5A5_A5A5;
        tick();
        tick();
        PSLVERR = 1'b0;
        check("err_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("err_rsp_err", {31'd0, rsp_err}, 32'd1);
        check("err_rsp_rdata", rsp_rdata, 32'hA5A5_A5A5);
        check("err_idle_sels", sels(), 32'd0);
        check("err_idle_enable", {31'd0, enable}, 32'd0);
        tick();

        // Back-to-back writes: slave 1 then slave 3 without an IDLE cycle
        request(1'b1, 32'h0000_0000, 32'h1111_1111);
        tick();
        check("b2b_setup1_sels", sels(), 32'h1);
        request(1'b1, 32'h8000_0000, 32'h2222_2222);
        #1;
        check("b2b_setup1_ready", {31'd0, req_ready}, 32'd0);
        tick();
        check("b2b_access1_sels", sels(), 32'h1);
        check("b2b_access1_enable", {31'd0, enable}, 32'd1);
        check("b2b_access1_data", data, 32'h1111_1111);
        tick();
        req_valid = 1'b0;
        check("b2b_setup2_sels", sels(), 32'h4);
        check("b2b_setup2_enable", {31'd0, enable}, 32'd0);
        check("b2b_setup2_data", data, 32'h2222_2222);
        check("b2b_rsp1_valid", {31'd0, rsp_valid}, 32'd1);
        tick();
        check("b2b_access2_enable", {31'd0, enable}, 32'd1);
        check("b2b_gap_rsp", {31'd0, rsp_valid}, 32'd0);
        tick();
        check("b2b_rsp2_valid", {31'd0, rsp_valid}, 32'd1);
        check("b2b_rsp2_err", {31'd0, rsp_err}, 32'd0);
        check("b2b_idle_sels", sels(), 32'd0);
        tick();

        // Slave never ready
        PREADY = 1'b0;
        PRDATA = 32'hDEAD_0000;
        request(1'b0, 32'h4000_0100, 32'h0);
        tick();
        req_valid = 1'b0;
        tick();
        check("to_access1_enable", {31'd0, enable}, 32'd1);
`ifdef APB_TIMEOUT_EN
        for (int i = 2; i <= 16; i++) begin
            tick();
            check($sformatf("to_access%0d_enable", i), {31'd0, enable}, 32'd1);
            check($sformatf("to_access%0d_rsp", i), {31'd0, rsp_valid}, 32'd0);
        end
        tick();
        check("to_abort_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("to_abort_rsp_err", {31'd0, rsp_err}, 32'd1);
        check("to_abort_rsp_rdata", rsp_rdata, 32'd0);
        check("to_abort_enable", {31'd0, enable}, 32'd0);
        check("to_abort_sels", sels(), 32'd0);
        PREADY = 1'b1;
        tick();
        check("to_late_ready_rsp", {31'd0, rsp_valid}, 32'd0);
        check("to_late_ready_enable", {31'd0, enable}, 32'd0);
`else
        for (int i = 2; i <= 100; i++) begin
            tick();
            if (rsp_valid !== 1'b0 || enable !== 1'b1) begin
                check($sformatf("noto_access%0d_enable", i), {31'd0, enable}, 32'd1);
                check($sformatf("noto_access%0d_rsp", i), {31'd0, rsp_valid}, 32'd0);
            end
        end
        check("noto_cycle100_enable", {31'd0, enable}, 32'd1);
        check("noto_cycle100_sels", sels(), 32'h2);
        check("noto_cycle100_rsp", {31'd0, rsp_valid}, 32'd0);
        PREADY = 1'b1;
        PRDATA = 32'h0BAD_CAFE;
        tick();
        check("noto_final_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("noto_final_rdata", rsp_rdata, 32'h0BAD_CAFE);
`endif

        // Reset during ACCESS aborts silently
        PREADY = 1'b0;
        request(1'b1, 32'hC000_0000, 32'h5555_5555);
        tick();
        req_valid = 1'b0;
        tick();
        check("mid_access_enable", {31'd0, enable}, 32'd1);
        PRESET = 1'b1;
        PREADY = 1'b1;
        tick();
        check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("mid_rst_sels", sels(), 32'd0);
        check("mid_rst_enable", {31'd0, enable}, 32'd0);
        check("mid_rst_addr", addr, 32'd0);
        PRESET = 1'b0;
        tick();
        check("mid_rst_after_rsp", {31'd0, rsp_valid}, 32'd0);
        check("mid_rst_after_ready", {31'd0, req_ready}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
